// File: rtl/out_port_logger.sv
// out_port_logger: captures every change of the core output word with a cycle timestamp into a show-ahead FIFO
// Ports: clk/rst (sync, active-high); en gates capture; core_out is the watched word;
// clr_ovf clears overflow/drop_cnt; rd_valid/rd_ready/rd_data/rd_ts form the read side;
// count is occupancy; overflow is sticky on any drop; drop_cnt saturates at 255.
module out_port_logger #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        core_out,
  input  logic                    clr_ovf,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic [TS_WIDTH-1:0]     rd_ts,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [TS_WIDTH-1:0] ts_q;
  logic [WIDTH-1:0]    prev_q;
  logic                armed_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_q, drop_d, drop_base;
  logic [WIDTH-1:0]    mem_data_q [DEPTH];
  logic [TS_WIDTH-1:0] mem_ts_q [DEPTH];
  logic                evt, pop, full, push, drop;
  always_comb begin
    evt       = en && (armed_q || core_out != prev_q);
    pop       = count_q != '0 && rd_ready;
    full      = count_q == CW'(DEPTH);
    // a same-cycle pop frees the slot, so a full FIFO can still accept
    push      = evt && (!full || pop);
    drop      = evt && full && !pop;
    count_d   = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
    // a drop on the clearing edge restarts the count at 1
    ovf_d     = drop || (ovf_q && !clr_ovf);
    drop_base = clr_ovf ? 8'd0 : drop_q;
    drop_d    = (drop && drop_base != 8'hff) ? drop_base + 8'd1 : drop_base;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      prev_q   <= '0;
      armed_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_q + TS_WIDTH'(1);
      prev_q   <= en ? core_out : prev_q;
      armed_q  <= !en;
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= core_out;
      mem_ts_q[wr_ptr_q]   <= ts_q;
    end
  end
  assign rd_valid = count_q != '0;
  assign rd_data  = mem_data_q[rd_ptr_q];
  assign rd_ts    = mem_ts_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_out_port_logger.sv
// tb_out_port_logger: table-driven and directed checks of out_port_logger
module tb_out_port_logger;
  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, clr_ovf = 1'b0, rd_ready = 1'b0;
  logic [31:0] core_out = '0;
  logic        rd_valid, overflow;
  logic [31:0] rd_data;
  logic [15:0] rd_ts;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;
  int checks = 0, failures = 0;
  typedef struct {
    logic r, e, c, y;
    logic [31:0] d;
    logic v;
    logic [31:0] ed;
    logic [15:0] et;
    logic [3:0] ec;
    logic eo;
    logic [7:0] edc;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  out_port_logger dut (
    .clk(clk), .rst(rst), .en(en), .core_out(core_out), .clr_ovf(clr_ovf),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ts(rd_ts),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  function automatic void add(input logic r, e, c, y, input logic [31:0] d, input logic v,
                              input logic [31:0] ed, input logic [15:0] et, input logic [3:0] ec,
                              input logic eo, input logic [7:0] edc);
    vq.push_back('{r, e, c, y, d, v, ed, et, ec, eo, edc});
  endfunction
  function automatic void add_rst();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0d: got=%h expected=%h", nm, idx, act, exp);
    end
  endtask
  task automatic step(input logic r, e, c, y, input logic [31:0] d);
    rst = r; en = e; clr_ovf = c; rd_ready = y; core_out = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // steady output: one entry only
    add_rst();
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 32'h1, 1, 32'h1, 16'd0, 1, 0, 0);
    // change tracking from ts=5, then drain
    add_rst();
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 32'h1, 1, 32'h1, 16'd5, 1, 0, 0);
    add(0, 1, 0, 0, 32'h2, 1, 32'h1, 16'd5, 2, 0, 0);
    add(0, 1, 0, 0, 32'h2, 1, 32'h1, 16'd5, 2, 0, 0);
    add(0, 1, 0, 0, 32'h4, 1, 32'h1, 16'd5, 3, 0, 0);
    add(0, 0, 0, 1, 32'h0, 1, 32'h2, 16'd6, 2, 0, 0);
    add(0, 0, 0, 1, 32'h0, 1, 32'h4, 16'd8, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0);
    // shift-left overflow, read-out, clear
    add_rst();
    for (int i = 0; i < 12; i++)
      add(0, 1, 0, 0, 32'h1 << i, 1, 32'h1, 16'd0, 4'(i < 8 ? i + 1 : 8), i >= 8, 8'(i >= 8 ? i - 7 : 0));
    for (int j = 0; j < 8; j++)
      add(0, 0, 0, 1, 0, j < 7, 32'h1 << (j + 1), 16'(j + 1), 4'(7 - j), 1, 4);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // full with simultaneous push/pop, drop vs clear, partial drain, mid reset
    add_rst();
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 32'h10 + i, 1, 32'h10, 16'd0, 4'(i + 1), 0, 0);
    for (int j = 0; j < 4; j++) add(0, 1, 0, 1, 32'h20 + j, 1, 32'h11 + j, 16'(j + 1), 8, 0, 0);
    add(0, 1, 1, 0, 32'h99, 1, 32'h14, 16'd4, 8, 1, 1);
    add(0, 1, 0, 0, 32'h9A, 1, 32'h14, 16'd4, 8, 1, 2);
    add(0, 0, 1, 0, 32'h0, 1, 32'h14, 16'd4, 8, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 0, 1, 32'h15 + k, 16'(5 + k), 4'(7 - k), 0, 0);
    add_rst();
    // en gating and re-arm, empty push with rd_ready, rd_ready while empty
    add(0, 1, 0, 1, 32'h55, 1, 32'h55, 16'd0, 1, 0, 0);
    add(0, 1, 0, 1, 32'h55, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 32'h11 * (i + 1), 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 32'h55, 1, 32'h55, 16'd7, 1, 0, 0);
    foreach (vq[i]) begin
      step(vq[i].r, vq[i].e, vq[i].c, vq[i].y, vq[i].d);
      chk("rd_valid", i, 32'(rd_valid), 32'(vq[i].v));
      chk("count", i, 32'(count), 32'(vq[i].ec));
      chk("overflow", i, 32'(overflow), 32'(vq[i].eo));
      chk("drop_cnt", i, 32'(drop_cnt), 32'(vq[i].edc));
      if (vq[i].v) begin
        chk("rd_data", i, rd_data, vq[i].ed);
        chk("rd_ts", i, 32'(rd_ts), 32'(vq[i].et));
      end
    end
    // timestamp wrap: the 65539th edge after reset sees ts=2
    step(1, 0, 0, 0, 0);
    repeat (65538) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'hABCD);
    chk("wrap_valid", 0, 32'(rd_valid), 1);
    chk("wrap_data", 0, rd_data, 32'hABCD);
    chk("wrap_ts", 0, 32'(rd_ts), 2);
    // drop counter saturation: 262 drops must stop at 255
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 270; i++) step(0, 1, 0, 0, 32'(i));
    chk("sat_drop", 0, 32'(drop_cnt), 255);
    chk("sat_ovf", 0, 32'(overflow), 1);
    chk("sat_count", 0, 32'(count), 8);
    chk("sat_head", 0, rd_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/out_port_logger.md
Name: out_port_logger

Overview:
- Sink for the cyber_cobra output port (OUT_RD1): watches the 32-bit core output every cycle and records each value change with a cycle timestamp.
- Records go into a small show-ahead FIFO that a host or debug bus drains through a valid/ready read interface.
- Sits beside the core in the top-level and its testbenches; replaces $monitor-style printing with synthesizable capture.

Parameters:
- WIDTH, 32, width of the core output word.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- TS_WIDTH, 16, width of the free-running cycle timestamp.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable.
- core_out  input  WIDTH  core output word (OUT_RD1).
- clr_ovf  input  1  clears the overflow flag and the drop counter.
- rd_ready  input  1  host accepts the head entry.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  WIDTH  head entry value.
- rd_ts  output  TS_WIDTH  head entry timestamp.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when a record was dropped.
- drop_cnt  output  8  saturating count of dropped records.

Behaviour:
- Reset (rst=1 at a rising edge):
  - ts counter, count, rd_valid, overflow and drop_cnt all go to 0.
  - FIFO pointers are cleared.
  - prev register is cleared and the armed flag is set.
  - rd_data and rd_ts are don't-care while rd_valid=0.
  - Reset mid-operation discards all stored entries.
- Timestamp counter:
  - Increments by 1 every cycle rst=0, regardless of en.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Event detection at each rising edge with en=1:
  - Event occurs when armed=1 or core_out != prev.
  - The entry is {core_out, ts}, where ts is the counter value before that edge's increment.
  - On every en=1 edge: prev <= core_out and armed <= 0, whether or not the entry was stored.
- en=0 behaviour:
  - No events.
  - armed <= 1, so the first enabled cycle always logs its value.
  - prev is held.
- Latency: core_out sampled at edge N is visible on rd_valid, rd_data and rd_ts after edge N (1 cycle).
- Read side:
  - FIFO is show-ahead: rd_data and rd_ts come from the head slot of registered storage.
  - Pop occurs when rd_valid && rd_ready at a rising edge.
  - rd_ready while empty has no effect.
- Push/pop decision for each edge with an event:
  - count < DEPTH: store the entry.
  - count == DEPTH and a pop in the same cycle: store the entry; count stays DEPTH.
  - count == DEPTH and no pop: drop the entry. Set overflow=1 and increment drop_cnt, saturating at 255.
  - Empty FIFO with push and rd_ready: the entry is stored, not bypassed; it becomes valid next cycle.
- Occupancy: push without pop gives count+1; pop without push gives count-1; both gives no change.
- Overflow clearing:
  - clr_ovf=1 clears overflow and drop_cnt at that edge.
  - If a drop occurs on the same edge, the drop wins: overflow=1 and drop_cnt=1.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is taken from count, not from pointer comparison.

Test Plan:
- Reset then steady output:
  - rst high 1 cycle, then en=1 and core_out=0x0000_0001 held 10 cycles with rd_ready=0.
  - Required: exactly one entry (0x1, ts=0) appears one cycle after the first enabled edge; count=1.
- Change tracking (rd_ready=0):
  - core_out goes 0x1, 0x2, 0x2, 0x4 on consecutive enabled edges starting at ts=5.
  - Required: entries (0x1,5), (0x2,6), (0x4,8); count=3.
- Cycle-shift-left pattern:
  - core_out = 0x1 rotated left each cycle for 12 cycles, DEPTH=8, rd_ready=0.
  - Required: count saturates at 8, overflow=1, drop_cnt=4.
  - Read-out returns 0x1..0x80 in order.
- Full with simultaneous push and pop:
  - Fill to 8, then hold rd_ready=1 while the value changes every cycle.
  - Required: count stays 8, overflow stays 0, values pop in order.
- en gating and re-arm:
  - en=0 for 5 cycles while core_out changes, then en=1 with core_out=0x55 (equal to prev).
  - Required: no entries while disabled; one entry 0x55 on the first enabled edge.
- Clear, reset and wrap:
  - clr_ovf pulse after overflow: required overflow=0, drop_cnt=0.
  - rst asserted with count=5: required count=0 and rd_valid=0 next cycle.
  - Run 65536+3 cycles: required ts wraps to 0x0002 on the logged entry.
